// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the pad lines, deframes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) into a first-word-fall-through byte FIFO.
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_clk_filt, r_clk_filt_d;
    logic [FW-1:0] r_filt_cnt;
    logic [1:0]    r_state, w_state_nxt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;
    logic          r_parity_err, r_frame_err, r_overflow;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;

    logic          w_sample, w_timeout;
    logic          w_start, w_shift, w_cap_par, w_push_req, w_perr, w_ferr;
    logic          w_full, w_pop, w_push, w_ovf;
    logic [PW-1:0] w_wr_nxt, w_rd_nxt;
    logic          w_valid_nxt;
    logic [7:0]    w_head_nxt;

    // Pad synchronizers and clock deglitch filter
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_s1     <= ps2_clk;
            r_clk_s2     <= r_clk_s1;
            r_dat_s1     <= ps2_dat;
            r_dat_s2     <= r_dat_s1;
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_s2 != r_clk_filt) begin
                if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                    r_clk_filt <= r_clk_s2;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + FW'(1);
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    assign w_sample  = r_clk_filt_d & ~r_clk_filt;
    assign w_timeout = (r_state != IDLE) && !w_sample && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Frame deframer: next state and per-event strobes
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_cap_par   = 1'b0;
        w_push_req  = 1'b0;
        w_perr      = 1'b0;
        w_ferr      = 1'b0;
        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_ferr      = 1'b1;
        end else if (w_sample) begin
            case (r_state)
                IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_nxt = DATA;
                        w_start     = 1'b1;
                    end
                end
                DATA: begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
                end
                PARITY: begin
                    w_cap_par   = 1'b1;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    if (!r_dat_s2)               w_ferr     = 1'b1;
                    else if (!(^{r_shift, r_par})) w_perr   = 1'b1;
                    else                          w_push_req = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_to_cnt     <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_start)      r_bit_cnt <= '0;
            else if (w_shift) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_shift)   r_shift <= {r_dat_s2, r_shift[7:1]};
            if (w_cap_par) r_par   <= r_dat_s2;
            if (w_sample || w_timeout || (r_state == IDLE)) r_to_cnt <= '0;
            else                                             r_to_cnt <= r_to_cnt + TW'(1);
            r_parity_err <= w_perr;
            r_frame_err  <= w_ferr;
            r_overflow   <= w_ovf;
        end
    end

    // FIFO control; the head byte and valid flag are precomputed so both outputs come from flops
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop       = r_rx_valid & rx_ready;
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_ovf       = w_push_req & w_full & ~w_pop;
    assign w_wr_nxt    = w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
    assign w_rd_nxt    = w_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;
    assign w_valid_nxt = (w_wr_nxt != w_rd_nxt);
    assign w_head_nxt  = (w_push && (r_wr_ptr[AW-1:0] == w_rd_nxt[AW-1:0])) ? r_shift
                                                                           : r_mem[w_rd_nxt[AW-1:0]];

    always_ff @(posedge CLOCK_50) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_rx_valid <= w_valid_nxt;
            r_rx_data  <= w_valid_nxt ? w_head_nxt : 8'h00;
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: drives bit-level PS/2 frames and checks bytes and error pulses
// against a frame-outcome model computed from the PS/2 framing rules.
module tb_ps2_rx;

    localparam int unsigned FL    = 8;
    localparam int unsigned TO    = 1000;
    localparam int unsigned DEPTH = 4;
    localparam int          HP    = 20;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_dat  = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overflow;

    int n_vec = 0;
    int n_bad = 0;
    int n_perr = 0, n_ferr = 0, n_ovf = 0;
    logic [7:0] got[$];

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Pulse counting and consumed-byte capture, away from the active edge
    always @(negedge CLOCK_50) begin
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
        if (overflow)   n_ovf++;
        if (rx_valid && rx_ready) got.push_back(rx_data);
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // Reference model: parity bit giving an odd count of ones, and frame outcome
    function automatic logic odd_par(logic [7:0] d);
        return ($countones(d) % 2 == 0);
    endfunction

    // 0 = byte delivered, 1 = parity error, 2 = framing error
    function automatic int outcome(logic [7:0] d, logic par, logic stop);
        if (!stop) return 2;
        if (($countones({d, par}) % 2) == 0) return 1;
        return 0;
    endfunction

    task automatic wait_cyc(int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_bit(logic b);
        ps2_dat = b;
        wait_cyc(HP);
        ps2_clk = 1'b0;
        wait_cyc(HP);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(logic [7:0] d, logic par, logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stop);
        ps2_dat = 1'b1;
        wait_cyc(HP);
    endtask

    task automatic test_reset;
        #3 RESET_N = 1'b0;
        #5;
        n_vec++;
        if ({rx_valid, rx_data, parity_err, frame_err, overflow} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 000", {rx_valid, rx_data, parity_err, frame_err, overflow});
        end
        wait_cyc(4);
        RESET_N = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_single_byte;
        int lat;
        int p0, f0;
        p0 = n_perr; f0 = n_ferr; lat = -1;
        rx_ready = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h1C >> i) & 8'h01) != 0);
        send_bit(1'b0);
        ps2_dat = 1'b1;
        wait_cyc(HP);
        ps2_clk = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            wait_cyc(1);
            if (k == HP) ps2_clk = 1'b1;
            if (rx_valid && lat < 0) lat = k;
        end
        n_vec++;
        if (lat != int'(FL) + 3) begin
            n_bad++;
            $display("FAIL single_latency: got %0d cycles want %0d", lat, FL + 3);
        end
        n_vec++;
        if (rx_data !== 8'h1C) begin
            n_bad++;
            $display("FAIL single_data: got %h want 1c", rx_data);
        end
        n_vec++;
        if ((n_perr - p0) != 0 || (n_ferr - f0) != 0) begin
            n_bad++;
            $display("FAIL single_no_err: got perr %0d ferr %0d want 0 0", n_perr - p0, n_ferr - f0);
        end
        got.delete();
        rx_ready = 1'b1;
        wait_cyc(3);
        rx_ready = 1'b0;
        n_vec++;
        if (got.size() != 1 || rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pop: got %0d pops valid %b want 1 pop valid 0", got.size(), rx_valid);
        end
    endtask

    task automatic test_errors;
        int p0, f0;
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'hF0, 1'b0, 1'b1);
        wait_cyc(5);
        n_vec++;
        if ((n_perr - p0) != 1 || (n_ferr - f0) != 0 || rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL parity_err: got perr %0d ferr %0d valid %b want 1 0 0", n_perr - p0, n_ferr - f0, rx_valid);
        end
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h29, odd_par(8'h29), 1'b0);
        wait_cyc(5);
        n_vec++;
        if ((n_perr - p0) != 0 || (n_ferr - f0) != 1 || rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_err: got perr %0d ferr %0d valid %b want 0 1 0", n_perr - p0, n_ferr - f0, rx_valid);
        end
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h3C, ~odd_par(8'h3C), 1'b0);
        wait_cyc(5);
        n_vec++;
        if ((n_perr - p0) != 0 || (n_ferr - f0) != 1) begin
            n_bad++;
            $display("FAIL err_precedence: got perr %0d ferr %0d want 0 1", n_perr - p0, n_ferr - f0);
        end
    endtask

    task automatic test_overflow;
        int o0;
        logic [7:0] d;
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            o0 = n_ovf;
            d = 8'(i);
            send_frame(d, odd_par(d), 1'b1);
            n_vec++;
            if ((n_ovf - o0) != ((i == 5) ? 1 : 0)) begin
                n_bad++;
                $display("FAIL overflow_frame%0d: got %0d pulses want %0d", i, n_ovf - o0, (i == 5) ? 1 : 0);
            end
        end
        rx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLOCK_50);
            n_vec++;
            if (rx_valid !== 1'b1 || rx_data !== 8'(k + 1)) begin
                n_bad++;
                $display("FAIL drain%0d: got valid %b data %h want 1 %h", k, rx_valid, rx_data, 8'(k + 1));
            end
        end
        @(negedge CLOCK_50);
        n_vec++;
        if (rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty: got valid %b want 0", rx_valid);
        end
        wait_cyc(2);
    endtask

    task automatic test_glitch_timeout;
        int p0, f0, lat;
        p0 = n_perr; f0 = n_ferr; lat = -1;
        rx_ready = 1'b1;
        got.delete();
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(30);
        send_frame(8'h12, odd_par(8'h12), 1'b1);
        n_vec++;
        if (got.size() != 1 || got[0] !== 8'h12 || (n_perr - p0) != 0 || (n_ferr - f0) != 0) begin
            n_bad++;
            $display("FAIL glitch_ignored: got %0d bytes perr %0d ferr %0d want 1 byte 12 no errors",
                     got.size(), n_perr - p0, n_ferr - f0);
        end
        f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        ps2_dat = 1'b0;
        wait_cyc(HP);
        ps2_clk = 1'b0;
        for (int k = 1; k <= int'(FL + TO) + 40; k++) begin
            wait_cyc(1);
            if (k == HP) begin
                ps2_clk = 1'b1;
                ps2_dat = 1'b1;
            end
            if (frame_err && lat < 0) lat = k;
        end
        n_vec++;
        if (lat != int'(FL + TO) + 3 || (n_ferr - f0) != 1) begin
            n_bad++;
            $display("FAIL timeout: got pulse at %0d count %0d want at %0d count 1", lat, n_ferr - f0, FL + TO + 3);
        end
        got.delete();
        send_frame(8'h5A, odd_par(8'h5A), 1'b1);
        n_vec++;
        if (got.size() != 1 || got[0] !== 8'h5A) begin
            n_bad++;
            $display("FAIL after_timeout: got %0d bytes first %h want 1 byte 5a", got.size(), (got.size() > 0) ? got[0] : 8'h00);
        end
    endtask

    task automatic test_reset_mid_frame;
        int p0, f0;
        rx_ready = 1'b0;
        send_frame(8'h33, odd_par(8'h33), 1'b1);
        n_vec++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h33) begin
            n_bad++;
            $display("FAIL preload: got valid %b data %h want 1 33", rx_valid, rx_data);
        end
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        RESET_N = 1'b0;
        #1;
        n_vec++;
        if ({rx_valid, rx_data, parity_err, frame_err, overflow} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_async: got %h want 000", {rx_valid, rx_data, parity_err, frame_err, overflow});
        end
        wait_cyc(5);
        RESET_N = 1'b1;
        wait_cyc(5);
        p0 = n_perr; f0 = n_ferr;
        got.delete();
        rx_ready = 1'b1;
        send_frame(8'hE0, odd_par(8'hE0), 1'b1);
        n_vec++;
        if (got.size() != 1 || got[0] !== 8'hE0 || (n_perr - p0) != 0 || (n_ferr - f0) != 0) begin
            n_bad++;
            $display("FAIL after_reset: got %0d bytes first %h perr %0d ferr %0d want 1 byte e0 no errors",
                     got.size(), (got.size() > 0) ? got[0] : 8'h00, n_perr - p0, n_ferr - f0);
        end
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic       par, stop;
        int         r, exp_o, p0, f0;
        rx_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            r    = int'($urandom_range(0, 5));
            par  = (r == 0) ? ~odd_par(d) : odd_par(d);
            stop = (r == 1) ? 1'b0 : 1'b1;
            exp_o = outcome(d, par, stop);
            p0 = n_perr; f0 = n_ferr;
            got.delete();
            send_frame(d, par, stop);
            n_vec++;
            if ((n_perr - p0) != ((exp_o == 1) ? 1 : 0) || (n_ferr - f0) != ((exp_o == 2) ? 1 : 0) ||
                got.size() != ((exp_o == 0) ? 1 : 0) || (exp_o == 0 && got[0] !== d)) begin
                n_bad++;
                $display("FAIL random%0d d=%h: got perr %0d ferr %0d bytes %0d first %h want outcome %0d",
                         n, d, n_perr - p0, n_ferr - f0, got.size(), (got.size() > 0) ? got[0] : 8'h00, exp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_errors();
        test_overflow();
        test_glitch_timeout();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
